// File: rtl/serial_in_port.sv
// Serial-to-parallel receiver for the port 4 serial line.
// LSB-first byte assembly with inter-bit timeout, frame-error and overrun flags.
module serial_in_port #(
    parameter int BITS    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            serial_in,
    input  logic            shift_en,
    input  logic            rd,
    output logic [BITS-1:0] data_out,
    output logic            ready,
    output logic            busy,
    output logic            frame_err,
    output logic            overrun
);
    localparam int CW = $clog2(BITS + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BITS_C = CW'(BITS);
    localparam logic [IW-1:0] TOUT_C = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BITS-1:0] r_shreg;
    logic [BITS-1:0] w_shreg_nxt;
    logic [CW-1:0]   r_bit_cnt;
    logic [CW-1:0]   w_bit_cnt_nxt;
    logic [IW-1:0]   r_idle_cnt;
    logic [IW-1:0]   w_idle_cnt_nxt;
    logic [BITS-1:0] r_data;
    logic [BITS-1:0] w_data_nxt;
    logic            r_ready;
    logic            w_ready_nxt;
    logic            r_ferr;
    logic            w_ferr_nxt;
    logic            r_ovr;
    logic            w_ovr_nxt;

    logic [BITS-1:0] w_shifted;
    logic [CW-1:0]   w_bit_inc;
    logic [IW-1:0]   w_idle_inc;

    assign w_shifted  = {serial_in, r_shreg[BITS-1:1]};
    assign w_bit_inc  = r_bit_cnt + 1'b1;
    assign w_idle_inc = r_idle_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_data     <= w_data_nxt;
            r_ready    <= w_ready_nxt;
            r_ferr     <= w_ferr_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        w_data_nxt     = r_data;
        w_ready_nxt    = r_ready;
        w_ferr_nxt     = r_ferr;
        w_ovr_nxt      = r_ovr;

        if (rd) begin
            w_ready_nxt = 1'b0;
            w_ferr_nxt  = 1'b0;
            w_ovr_nxt   = 1'b0;
        end

        unique case (r_state)
            IDLE: begin
                if (shift_en) begin
                    w_shreg_nxt    = w_shifted;
                    w_bit_cnt_nxt  = CW'(1);
                    w_idle_cnt_nxt = '0;
                    w_state_nxt    = RECV;
                end
            end
            RECV: begin
                if (shift_en) begin
                    w_shreg_nxt    = w_shifted;
                    w_idle_cnt_nxt = '0;
                    w_bit_cnt_nxt  = w_bit_inc;
                    if (w_bit_inc == BITS_C) begin
                        w_state_nxt = DONE;
                    end
                end else if (w_idle_inc == TOUT_C) begin
                    // Abort: partial byte dropped, last good byte kept
                    w_state_nxt    = IDLE;
                    w_ferr_nxt     = 1'b1;
                    w_shreg_nxt    = '0;
                    w_bit_cnt_nxt  = '0;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_idle_cnt_nxt = w_idle_inc;
                end
            end
            DONE: begin
                w_data_nxt     = r_shreg;
                w_ready_nxt    = 1'b1;
                w_ovr_nxt      = r_ovr | (r_ready & ~rd);
                w_bit_cnt_nxt  = '0;
                w_idle_cnt_nxt = '0;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data_out  = r_data;
    assign ready     = r_ready;
    assign busy      = (r_state != IDLE);
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
endmodule

// File: tb/tb_serial_in_port.sv
// Directed bench for serial_in_port.
// Each scenario task drives the line and checks outputs 1 time unit after the edge.
module tb_serial_in_port;
    localparam int BITS    = 8;
    localparam int TIMEOUT = 16;

    logic            CLK = 1'b0;
    logic            CLR = 1'b0;
    logic            serial_in = 1'b0;
    logic            shift_en = 1'b0;
    logic            rd = 1'b0;
    logic [BITS-1:0] data_out;
    logic            ready;
    logic            busy;
    logic            frame_err;
    logic            overrun;

    int tests = 0;
    int fails = 0;

    serial_in_port #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .serial_in (serial_in),
        .shift_en  (shift_en),
        .rd        (rd),
        .data_out  (data_out),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_read();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    // Strobes bits lo..hi of b, with gap idle cycles between strobes
    task automatic send_bits(input logic [7:0] b, input int lo,
                             input int hi, input int gap);
        for (int i = lo; i <= hi; i++) begin
            serial_in = b[i];
            shift_en  = 1'b1;
            step();
            shift_en  = 1'b0;
            if (i < hi) repeat (gap) step();
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        step();
        step();
        CLR = 1'b0;
        tests++;
        if ({data_out, ready, busy, frame_err, overrun} !== 12'h000) begin
            fails++;
            $display("FAIL reset: got %h/%b%b%b%b expected 00/0000",
                     data_out, ready, busy, frame_err, overrun);
        end
    endtask

    task automatic test_basic();
        send_bits(8'hA5, 0, 7, 0);
        tests++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_done_state: ready=%b busy=%b expected 0 1",
                     ready, busy);
        end
        step();
        tests++;
        if (data_out !== 8'hA5 || ready !== 1'b1 || busy !== 1'b0 ||
            frame_err !== 1'b0) begin
            fails++;
            $display("FAIL basic_byte: got %h r%b b%b f%b expected a5 r1 b0 f0",
                     data_out, ready, busy, frame_err);
        end
        do_read();
        tests++;
        if (ready !== 1'b0 || data_out !== 8'hA5) begin
            fails++;
            $display("FAIL basic_read: ready=%b data=%h expected 0 a5",
                     ready, data_out);
        end
    endtask

    task automatic test_timeout();
        send_bits(8'h3C, 0, 7, TIMEOUT - 1);
        step();
        tests++;
        if (data_out !== 8'h3C || ready !== 1'b1 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL gap_max: got %h r%b f%b expected 3c r1 f0",
                     data_out, ready, frame_err);
        end
        send_bits(8'h0F, 0, 2, 0);
        repeat (TIMEOUT - 1) step();
        tests++;
        if (busy !== 1'b1 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: busy=%b ferr=%b expected 1 0",
                     busy, frame_err);
        end
        step();
        tests++;
        if (busy !== 1'b0 || frame_err !== 1'b1 || data_out !== 8'h3C ||
            ready !== 1'b1) begin
            fails++;
            $display("FAIL timeout_abort: b%b f%b %h r%b expected b0 f1 3c r1",
                     busy, frame_err, data_out, ready);
        end
        do_read();
        tests++;
        if (frame_err !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: ferr=%b ready=%b expected 0 0",
                     frame_err, ready);
        end
    endtask

    task automatic test_overrun();
        send_bits(8'h11, 0, 7, 0);
        step();
        send_bits(8'h22, 0, 7, 2);
        step();
        tests++;
        if (data_out !== 8'h22 || ready !== 1'b1 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %h r%b o%b expected 22 r1 o1",
                     data_out, ready, overrun);
        end
        do_read();
        tests++;
        if (data_out !== 8'h22 || ready !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: got %h r%b o%b expected 22 r0 o0",
                     data_out, ready, overrun);
        end
    endtask

    task automatic test_rd_at_done();
        send_bits(8'h11, 0, 7, 0);
        step();
        send_bits(8'h7E, 0, 7, 0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        tests++;
        if (data_out !== 8'h7E || ready !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL rd_at_done: got %h r%b o%b expected 7e r1 o0",
                     data_out, ready, overrun);
        end
        do_read();
    endtask

    task automatic test_clr_midframe();
        send_bits(8'hFF, 0, 4, 0);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        tests++;
        if ({data_out, ready, busy, frame_err, overrun} !== 12'h000) begin
            fails++;
            $display("FAIL clr_mid: got %h/%b%b%b%b expected 00/0000",
                     data_out, ready, busy, frame_err, overrun);
        end
        send_bits(8'hC3, 0, 7, 0);
        tests++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL clr_refill_timing: ready=%b busy=%b expected 0 1",
                     ready, busy);
        end
        step();
        tests++;
        if (data_out !== 8'hC3 || ready !== 1'b1) begin
            fails++;
            $display("FAIL clr_refill: got %h r%b expected c3 r1",
                     data_out, ready);
        end
        do_read();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        pat = 16'h9A5C;
        shift_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            serial_in = pat[k];
            step();
            if (k == 8) begin
                tests++;
                if (data_out !== 8'h5C || ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_first: got %h r%b expected 5c r1",
                             data_out, ready);
                end
            end
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_midframe: busy=%b expected 1", busy);
        end
        serial_in = 1'b1;
        step();
        shift_en = 1'b0;
        step();
        tests++;
        if (data_out !== 8'hCD || overrun !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: got %h o%b expected cd o1",
                     data_out, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_overrun();
        test_rd_at_done();
        test_clr_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
